pic_int_control: RTL
====================

# pic_int_control

Interrupt control stage of the 8259 PIC, directly downstream of the IRQ input stage. It consumes the interrupt request register (`irr`) and the current mask, and performs fully-nested fixed-priority resolution. It owns the in-service register (ISR) and the `int_out` request line, runs the two-pulse INTA sequence, returns the acknowledged index to the IRQ stage so that stage clears the IRR bit, and drives the vector byte on the second INTA.

## Interface
- `SYNC_STAGES`, 2: flop stages synchronising `inta_n` into `clk`; legal range 2–3.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `irr`  in  8  pending requests from the IRQ input stage.
- `imr`  in  8  interrupt mask; 1 = masked.
- `icw2_vec`  in  5  vector bits T7..T3 from ICW2.
- `inta_n`  in  1  CPU interrupt acknowledge, active-low, asynchronous.
- `eoi_valid`  in  1  one-cycle EOI command strobe.
- `eoi_specific`  in  1  with `eoi_valid`: 1 = specific, 0 = non-specific.
- `eoi_level`  in  3  ISR bit index for specific EOI.
- `int_out`  out  1  interrupt request to the CPU.
- `ack_valid`  out  1  one-cycle pulse; the IRQ stage clears `irr[ack_idx]`.
- `ack_idx`  out  3  acknowledged IR index (highest_priority_idx).
- `isr`  out  8  in-service register.
- `vector`  out  8  `{icw2_vec, idx}`.
- `vector_oe`  out  1  vector bus drive enable.

## Operation
- Candidate set: `cand = irr & ~imr`. Priority is fixed: IR0 highest, IR7 lowest.
- Qualifying request: the lowest-index bit of `cand` whose index is strictly lower than the lowest set bit of `isr`. Any candidate qualifies when `isr == 0`.
- The FSM has four states; `inta_f` and `inta_r` are the synchronised falling and rising edges of `inta_n`.
  - IDLE: `int_out` is registered from "qualifying request exists". Go to ACK1 when `inta_f` and `int_out` are both 1.
  - ACK1 (entered on the first `inta_f`): latch the winner index `w`, set `isr[w]`, pulse `ack_valid` with `ack_idx = w`, drop `int_out`. Wait for `inta_r`, then go to ACK2W.
  - ACK2W: on `inta_f`, go to DRIVE.
  - DRIVE: `vector_oe = 1`, `vector = {icw2_vec, w}`. On `inta_r`, go to IDLE.
- Spurious request: if no qualifying request exists at the first `inta_f` (request withdrawn), then `w = 7`, `isr` is unchanged, `ack_valid` is not pulsed, and the sequence still completes with vector `{icw2_vec, 3'd7}`.
- `inta_f` while in IDLE with `int_out = 0` is ignored.
- EOI, accepted in any state:
  - Non-specific EOI clears the lowest-index set bit of `isr`; no-op if `isr == 0`.
  - Specific EOI clears `isr[eoi_level]`.
  - If an EOI and an ISR set land in the same cycle, the clear is applied first, then the set. The set wins on the same bit.
- Masking never clears ISR bits. A masked in-service level still blocks lower priorities.

## Timing
- Reset values: FSM = IDLE, `isr` = 0, `int_out` = 0, `ack_valid` = 0, `ack_idx` = 0, `vector` = 0, `vector_oe` = 0. Synchronizer flops reset to 1 (INTA inactive).
- `inta_n` edge detection latency: `SYNC_STAGES` + 1 cycles from pin to FSM action.
- `int_out` latency: rises 1 cycle after a qualifying `irr`/`imr`/`isr` condition appears. Falls the cycle after ACK1 entry, or 1 cycle after the condition disappears while in IDLE.
- `ack_valid` is high for exactly 1 cycle, on the cycle of ACK1 entry. `isr[w]` is visible the same cycle.
- `vector`/`vector_oe` are registered. Both are valid from the cycle after DRIVE entry until the cycle after `inta_r` is detected.
- Reset during any state returns the block to IDLE the next cycle and discards the sequence. `vector_oe` drops immediately.
- A new `int_out` may assert at the earliest 1 cycle after the return to IDLE.

## Configuration
- `PIC_AEOI_EN` defined: automatic EOI. `isr[w]` is cleared on the DRIVE→IDLE transition; `eoi_valid` is still honoured.
- `PIC_AEOI_EN` undefined: ISR bits clear only via EOI commands.

## Structure
- Shared package `pic_pkg` holds:
  - `NUM_IRQ` = 8
  - `pic_ctl_state_t` enum {IDLE, ACK1, ACK2W, DRIVE}
  - EOI type constants
- One sub-module, `pic_priority_resolver`: combinational lowest-index-first find over an 8-bit vector, returning an index and a valid flag. It is instantiated twice, once for `cand` and once for `isr`.

## Test plan
- `irr=8'h24`, `imr=0`, full INTA pair → `int_out` rises, `ack_idx=2`, `isr=8'h04`, `vector={icw2_vec,3'd2}`; with `icw2_vec=5'h08` the vector is `8'h42`.
- `isr=8'h04`, `irr=8'h10` → `int_out` stays 0. Then `irr=8'h01` → `int_out=1`, winner 0, `isr=8'h05`.
- `irr=8'h08`; `int_out` rises; `irr` drops to 0 before the first INTA → spurious: vector `{icw2_vec,3'd7}`, `isr` unchanged, no `ack_valid`.
- `isr=8'h0A`: non-specific EOI → `isr=8'h08`. Then specific EOI with `eoi_level=3` → `isr=8'h00`.
- Reset asserted in DRIVE → next cycle `vector_oe=0`, `isr=0`, FSM in IDLE, `int_out=0`.
- With `PIC_AEOI_EN`: `irr=8'h80`, INTA pair → `isr` bit 7 set in ACK1 and back to 0 the cycle after DRIVE exits.

Source files
------------

// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types and constants for the PIC interrupt control stage
package pic_pkg;

  localparam int NUM_IRQ = 8;
  localparam int IDX_W   = $clog2(NUM_IRQ);

  typedef enum logic [1:0] {
    IDLE,
    ACK1,
    ACK2W,
    DRIVE
  } pic_ctl_state_t;

  localparam logic EOI_NON_SPECIFIC = 1'b0;
  localparam logic EOI_SPECIFIC     = 1'b1;

endpackage

// File: rtl/pic_priority_resolver.sv
// rtl/pic_priority_resolver.sv - lowest-index-first find over an NUM_IRQ-bit vector
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IRQ-1:0] req,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pic_int_control.sv
// rtl/pic_int_control.sv - 8259 fully-nested priority, ISR and two-pulse INTA sequencing
// Optional PIC_AEOI_EN: automatic EOI of the acknowledged level when the vector cycle ends.
module pic_int_control
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irr,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic [4:0]         icw2_vec,
  input  logic               inta_n,
  input  logic               eoi_valid,
  input  logic               eoi_specific,
  input  logic [IDX_W-1:0]   eoi_level,
  output logic               int_out,
  output logic               ack_valid,
  output logic [IDX_W-1:0]   ack_idx,
  output logic [NUM_IRQ-1:0] isr,
  output logic [7:0]         vector,
  output logic               vector_oe
);

  logic [SYNC_STAGES-1:0] inta_sync;
  logic                   inta_prev;
  logic                   inta_s;
  logic                   inta_f;
  logic                   inta_r;

  pic_ctl_state_t state, state_next;

  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] isr_clr;
  logic [NUM_IRQ-1:0] isr_set;
  logic [IDX_W-1:0]   cand_idx;
  logic [IDX_W-1:0]   isr_idx;
  logic [IDX_W-1:0]   win_idx;
  logic               win_real;
  logic               cand_found;
  logic               isr_found;
  logic               qualify;
  logic               start_ack;

  // Synchroniser idles high so reset never looks like an acknowledge edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      inta_sync <= '1;
      inta_prev <= 1'b1;
    end else begin
      inta_sync <= {inta_sync[SYNC_STAGES-2:0], inta_n};
      inta_prev <= inta_s;
    end
  end

  assign inta_s = inta_sync[SYNC_STAGES-1];
  assign inta_f = inta_prev & ~inta_s;
  assign inta_r = ~inta_prev & inta_s;

  assign cand = irr & ~imr;

  pic_priority_resolver u_cand_res (
    .req   (cand),
    .idx   (cand_idx),
    .found (cand_found)
  );

  pic_priority_resolver u_isr_res (
    .req   (isr),
    .idx   (isr_idx),
    .found (isr_found)
  );

  // A masked in-service level still blocks everything below it.
  assign qualify = cand_found && (!isr_found || (cand_idx < isr_idx));

  always_comb begin
    state_next = state;
    start_ack  = 1'b0;
    case (state)
      IDLE: begin
        if (inta_f && int_out) begin
          state_next = ACK1;
          start_ack  = 1'b1;
        end
      end
      ACK1:    if (inta_r) state_next = ACK2W;
      ACK2W:   if (inta_f) state_next = DRIVE;
      DRIVE:   if (inta_r) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Clear mask is applied before the set mask, so a set on the same bit wins.
  always_comb begin
    isr_clr = '0;
    isr_set = '0;
    if (eoi_valid) begin
      if (eoi_specific == EOI_SPECIFIC) begin
        isr_clr[eoi_level] = 1'b1;
      end else if (isr_found) begin
        isr_clr[isr_idx] = 1'b1;
      end
    end
`ifdef PIC_AEOI_EN
    if ((state == DRIVE) && inta_r && win_real) begin
      isr_clr[win_idx] = 1'b1;
    end
`endif
    if (start_ack && qualify) begin
      isr_set[cand_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      isr       <= '0;
      win_idx   <= '0;
      win_real  <= 1'b0;
      int_out   <= 1'b0;
      ack_valid <= 1'b0;
      ack_idx   <= '0;
      vector    <= '0;
      vector_oe <= 1'b0;
    end else begin
      state     <= state_next;
      isr       <= (isr & ~isr_clr) | isr_set;
      int_out   <= (state == IDLE) && !start_ack && qualify;
      ack_valid <= start_ack && qualify;
      if (start_ack) begin
        win_idx  <= qualify ? cand_idx : IDX_W'(NUM_IRQ - 1);
        win_real <= qualify;
      end
      if (start_ack && qualify) begin
        ack_idx <= cand_idx;
      end
      vector_oe <= (state == DRIVE);
      vector    <= (state == DRIVE) ? {icw2_vec, win_idx} : 8'h00;
    end
  end

endmodule
